eq_tap_mac_sequencer: RTL and testbench



---
 rtl/eq_tap_mac_sequencer_if.sv | 34 +++
 rtl/eq_tap_mac_sequencer.sv | 145 ++++++++++++++
 tb/tb_eq_tap_mac_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_tap_mac_sequencer_if.sv
// Control/coefficient/tap-stream bundle between EQ control, the tap
// sequencer and the FIR coefficient load port.
interface eq_tap_mac_sequencer_if #(
  parameter int NBANDS = 4,
  parameter int GAIN_W = 2,
  parameter int NTAPS  = 32,
  parameter int COEF_W = 16
);
  localparam int BAND_W = (NBANDS > 1) ? $clog2(NBANDS) : 1;
  localparam int TAP_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  logic [NBANDS*GAIN_W-1:0] eqVal;
  logic                     start;
  logic                     coef_we;
  logic [BAND_W-1:0]        coef_band;
  logic [TAP_W-1:0]         coef_addr;
  logic [COEF_W-1:0]        coef_data;
  logic                     tap_ready;
  logic [COEF_W-1:0]        desiredTap;
  logic [TAP_W-1:0]         tapnum;
  logic                     tap_valid;
  logic                     busy;
  logic                     done;

  modport master (
    output eqVal, start, coef_we, coef_band, coef_addr, coef_data, tap_ready,
    input  desiredTap, tapnum, tap_valid, busy, done
  );

  modport slave (
    input  eqVal, start, coef_we, coef_band, coef_addr, coef_data, tap_ready,
    output desiredTap, tapnum, tap_valid, busy, done
  );
endinterface

// File: rtl/eq_tap_mac_sequencer.sv
// Builds each FIR tap as a gain-weighted sum of per-band base coefficients,
// one band per cycle, and streams the saturated taps out with a handshake.
module eq_tap_mac_sequencer #(
  parameter int NBANDS = 4,
  parameter int GAIN_W = 2,
  parameter int NTAPS  = 32,
  parameter int COEF_W = 16
) (
  input logic                   clk,
  input logic                   reset,
  eq_tap_mac_sequencer_if.slave bus
);
  localparam int BAND_W = (NBANDS > 1) ? $clog2(NBANDS) : 1;
  localparam int TAP_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int PROD_W = COEF_W + GAIN_W + 1;
  localparam int ACC_W  = COEF_W + GAIN_W + BAND_W + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-COEF_W+1){1'b0}}, {(COEF_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-COEF_W+1){1'b1}}, {(COEF_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [COEF_W-1:0] r_table [NBANDS][NTAPS];
  logic [NBANDS*GAIN_W-1:0] r_gain, w_gain_nxt;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [BAND_W-1:0]        r_band, w_band_nxt;
  logic [TAP_W-1:0]         r_n, w_n_nxt;
  logic [COEF_W-1:0]        r_tap, w_tap_nxt;
  logic [TAP_W-1:0]         r_tapnum, w_tapnum_nxt;
  logic                     r_valid, w_valid_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     r_done, w_done_nxt;

  logic [GAIN_W-1:0]        w_gain_sel;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic [COEF_W-1:0]        w_sat;

  // Unsigned gain is zero-extended so the multiply stays signed.
  assign w_gain_sel = r_gain[r_band*GAIN_W +: GAIN_W];
  assign w_coef     = r_table[r_band][r_n];
  assign w_prod     = $signed({1'b0, w_gain_sel}) * w_coef;
  assign w_sum      = r_acc + $signed({{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod});

  always_comb begin
    if (w_sum > SAT_MAX)      w_sat = SAT_MAX[COEF_W-1:0];
    else if (w_sum < SAT_MIN) w_sat = SAT_MIN[COEF_W-1:0];
    else                      w_sat = w_sum[COEF_W-1:0];
  end

  // NOTE: every output gets a default before the case so no path leaves a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_gain_nxt   = r_gain;
    w_acc_nxt    = r_acc;
    w_band_nxt   = r_band;
    w_n_nxt      = r_n;
    w_tap_nxt    = r_tap;
    w_tapnum_nxt = r_tapnum;
    w_valid_nxt  = r_valid;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: if (bus.start) begin
        w_gain_nxt  = bus.eqVal;
        w_acc_nxt   = '0;
        w_band_nxt  = '0;
        w_n_nxt     = '0;
        w_busy_nxt  = 1'b1;
        w_state_nxt = S_MAC;
      end
      S_MAC: begin
        w_acc_nxt = w_sum;
        if (r_band == BAND_W'(NBANDS-1)) begin
          w_tap_nxt    = w_sat;
          w_tapnum_nxt = r_n;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = S_OUT;
        end else begin
          w_band_nxt = r_band + BAND_W'(1);
        end
      end
      S_OUT: if (bus.tap_ready) begin
        w_valid_nxt = 1'b0;
        if (r_n == TAP_W'(NTAPS-1)) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_n_nxt     = r_n + TAP_W'(1);
          w_acc_nxt   = '0;
          w_band_nxt  = '0;
          w_state_nxt = S_MAC;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gain   <= '0;
      r_acc    <= '0;
      r_band   <= '0;
      r_n      <= '0;
      r_tap    <= '0;
      r_tapnum <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_gain   <= w_gain_nxt;
      r_acc    <= w_acc_nxt;
      r_band   <= w_band_nxt;
      r_n      <= w_n_nxt;
      r_tap    <= w_tap_nxt;
      r_tapnum <= w_tapnum_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // NOTE: the coefficient table has no reset so it maps onto plain RAM and
  // survives a sequence abort.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.coef_we)
      r_table[bus.coef_band][bus.coef_addr] <= bus.coef_data;
  end

  assign bus.desiredTap = r_tap;
  assign bus.tapnum     = r_tapnum;
  assign bus.tap_valid  = r_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_eq_tap_mac_sequencer.sv
// Self-checking bench for eq_tap_mac_sequencer: table vectors, hand-written
// corner sequences and randomized tables checked against a behavioural model.
module tb_eq_tap_mac_sequencer;
  localparam int NBANDS = 4;
  localparam int GAIN_W = 2;
  localparam int NTAPS  = 4;
  localparam int COEF_W = 16;
  localparam int PERIOD = NTAPS * (NBANDS + 1);

  typedef struct packed {
    logic [7:0]       eq;
    logic [3:0][15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  eq_tap_mac_sequencer_if #(.NBANDS(NBANDS), .GAIN_W(GAIN_W), .NTAPS(NTAPS), .COEF_W(COEF_W)) bus ();

  eq_tap_mac_sequencer #(.NBANDS(NBANDS), .GAIN_W(GAIN_W), .NTAPS(NTAPS), .COEF_W(COEF_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          mtab [NBANDS][NTAPS];
  logic [15:0] exp_tap [NTAPS];
  int          bp_tap, bp_len;
  logic [15:0] got_tap [$];
  int          got_num [$];
  int          got_cyc [$];
  int          done_cnt, done_cyc, busy_err, num_at_done;
  logic        busy_at_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_tap(input logic [7:0] eq, input int n);
    int acc = 0;
    for (int b = 0; b < NBANDS; b++) acc += int'(eq[b*GAIN_W +: GAIN_W]) * mtab[b][n];
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  task automatic wr(input int b, input int a, input logic [15:0] d);
    bus.coef_we   = 1'b1;
    bus.coef_band = 2'(b);
    bus.coef_addr = 2'(a);
    bus.coef_data = d;
    tick();
    bus.coef_we = 1'b0;
    mtab[b][a] = int'($signed(d));
  endtask

  // Runs one full sequence from IDLE; optional write on the start edge and an
  // optional mid-sequence disturbance (eqVal change, restart, write attempt).
  task automatic run_seq(input logic [7:0] eq, input bit disturb, input bit wr_en,
                         input int wb, input int wa, input logic [15:0] wd);
    int cyc, stall;
    logic ready;
    got_tap.delete(); got_num.delete(); got_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_err = 0; num_at_done = -1; busy_at_done = 1'bx;
    stall = 0;
    bus.eqVal = eq;
    bus.start = 1'b1;
    bus.tap_ready = 1'b1;
    if (wr_en) begin
      bus.coef_we = 1'b1; bus.coef_band = 2'(wb); bus.coef_addr = 2'(wa); bus.coef_data = wd;
      mtab[wb][wa] = int'($signed(wd));
    end
    tick();
    bus.start = 1'b0;
    bus.coef_we = 1'b0;
    cyc = 0;
    while (cyc < 300 && !(done_cyc >= 0 && cyc >= done_cyc + 2)) begin
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc; busy_at_done = bus.busy; num_at_done = int'(bus.tapnum);
        end
      end else if (done_cyc < 0 && !bus.busy) busy_err++;
      if (disturb && cyc == 7) begin
        bus.eqVal = 8'h00; bus.start = 1'b1;
        bus.coef_we = 1'b1; bus.coef_band = 2'd1; bus.coef_addr = 2'd3; bus.coef_data = 16'h0100;
      end else if (disturb && cyc == 8) begin
        bus.start = 1'b0; bus.coef_we = 1'b0;
      end
      if (bus.tap_valid && int'(bus.tapnum) == bp_tap && stall < bp_len) begin
        ready = 1'b0;
        stall++;
        check("bp_hold_tap", 32'(bus.desiredTap), 32'(exp_tap[bp_tap]));
        check("bp_hold_num", 32'(bus.tapnum), 32'(bp_tap));
      end else ready = 1'b1;
      bus.tap_ready = ready;
      if (bus.tap_valid && ready) begin
        got_tap.push_back(bus.desiredTap);
        got_num.push_back(int'(bus.tapnum));
        got_cyc.push_back(cyc);
      end
      tick();
      cyc++;
    end
    bus.tap_ready = 1'b1;
    if (done_cyc < 0) check("seq_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_run(input string tag);
    check({tag, "_ntaps"}, 32'(got_tap.size()), 32'(NTAPS));
    for (int i = 0; i < got_tap.size() && i < NTAPS; i++) begin
      check($sformatf("%s_tap%0d", tag, i), 32'(got_tap[i]), 32'(exp_tap[i]));
      check($sformatf("%s_num%0d", tag, i), 32'(got_num[i]), 32'(i));
      check($sformatf("%s_cyc%0d", tag, i), 32'(got_cyc[i]),
            32'(NBANDS + (NBANDS + 1) * i + ((i >= bp_tap) ? bp_len : 0)));
    end
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(PERIOD + bp_len));
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    check({tag, "_busy_early_drop"}, 32'(busy_err), 32'd0);
    check({tag, "_num_at_done"}, 32'(num_at_done), 32'(NTAPS - 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    int cnt;
    vecs[0] = '{8'hF4, {16'd7, 16'd6, 16'd5, 16'd4}};
    vecs[1] = '{8'h00, {16'd0, 16'd0, 16'd0, 16'd0}};
    vecs[2] = '{8'h01, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}};
    vecs[3] = '{8'h03, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}};
    vecs[4] = '{8'h08, {16'd8, 16'd6, 16'd4, 16'd2}};
    vecs[5] = '{8'h30, {16'd3, 16'd3, 16'd3, 16'd3}};
    vecs[6] = '{8'hC4, {16'd4, 16'd3, 16'd2, 16'd1}};

    reset = 1'b1;
    bus.eqVal = '0; bus.start = 1'b0; bus.coef_we = 1'b0; bus.coef_band = '0;
    bus.coef_addr = '0; bus.coef_data = '0; bus.tap_ready = 1'b0;
    bp_tap = -1; bp_len = 0;
    repeat (3) tick();
    check("rst_valid", 32'(bus.tap_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_tap", 32'(bus.desiredTap), 32'd0);
    check("rst_num", 32'(bus.tapnum), 32'd0);
    reset = 1'b0;
    tick();

    for (int n = 0; n < NTAPS; n++) begin
      wr(0, n, 16'h7FFF);
      wr(1, n, 16'(n + 1));
      wr(2, n, 16'd1);
      wr(3, n, 16'd0);
    end

    // Table-driven vectors on the reference coefficient table.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NTAPS; i++) exp_tap[i] = vecs[v].exp[i];
      run_seq(vecs[v].eq, 1'b0, 1'b0, 0, 0, 16'h0);
      check_run($sformatf("vec%0d", v));
    end

    // Write on the start edge is used by the sequence.
    exp_tap[0] = 16'd12; exp_tap[1] = 16'd5; exp_tap[2] = 16'd6; exp_tap[3] = 16'd7;
    run_seq(8'hF4, 1'b0, 1'b1, 1, 0, 16'd9);
    check_run("startwr");
    wr(1, 0, 16'd1);

    // Saturation at both rails.
    wr(2, 0, 16'h7000); wr(3, 0, 16'h7000);
    for (int i = 0; i < NTAPS; i++) exp_tap[i] = model_tap(8'hF0, i);
    check("sat_pos_model", 32'(exp_tap[0]), 32'h7FFF);
    exp_tap[0] = 16'h7FFF;
    run_seq(8'hF0, 1'b0, 1'b0, 0, 0, 16'h0);
    check_run("sat_pos");
    wr(2, 0, 16'h9000); wr(3, 0, 16'h9000);
    for (int i = 0; i < NTAPS; i++) exp_tap[i] = model_tap(8'hF0, i);
    exp_tap[0] = 16'h8000;
    run_seq(8'hF0, 1'b0, 1'b0, 0, 0, 16'h0);
    check_run("sat_neg");
    wr(2, 0, 16'd1); wr(3, 0, 16'd0);

    // Backpressure on tap 1.
    exp_tap[0] = 16'd4; exp_tap[1] = 16'd5; exp_tap[2] = 16'd6; exp_tap[3] = 16'd7;
    bp_tap = 1; bp_len = 7;
    run_seq(8'hF4, 1'b0, 1'b0, 0, 0, 16'h0);
    check_run("backpressure");
    bp_tap = -1; bp_len = 0;

    // Mid-sequence eqVal change, restart and write are all ignored.
    run_seq(8'hF4, 1'b1, 1'b0, 0, 0, 16'h0);
    check_run("snapshot");
    run_seq(8'hF4, 1'b0, 1'b0, 0, 0, 16'h0);
    check_run("lockout_rerun");

    // Reset during the tap-2 accumulation.
    bus.eqVal = 8'hF4; bus.tap_ready = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (12) tick();
    check("midrst_pre_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", 32'(bus.tap_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_tap", 32'(bus.desiredTap), 32'd0);
    check("midrst_num", 32'(bus.tapnum), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    cnt = 0;
    repeat (25) begin
      tick();
      if (bus.done || bus.tap_valid || bus.busy) cnt++;
    end
    check("midrst_quiet", 32'(cnt), 32'd0);
    run_seq(8'hF4, 1'b0, 1'b0, 0, 0, 16'h0);
    check_run("midrst_rerun");

    // Randomized tables, gains and backpressure against the model.
    for (int k = 0; k < 8; k++) begin
      logic [7:0] eq;
      repeat (6) wr(int'($urandom_range(0, NBANDS - 1)), int'($urandom_range(0, NTAPS - 1)),
                    16'($urandom));
      eq = 8'($urandom);
      bp_tap = int'($urandom_range(0, NTAPS - 1));
      bp_len = int'($urandom_range(0, 3));
      for (int i = 0; i < NTAPS; i++) exp_tap[i] = model_tap(eq, i);
      run_seq(eq, 1'b0, 1'b0, 0, 0, 16'h0);
      check_run($sformatf("rand%0d", k));
    end
    bp_tap = -1; bp_len = 0;

    // Zero gains give zero taps whatever the table holds.
    for (int i = 0; i < NTAPS; i++) exp_tap[i] = 16'd0;
    run_seq(8'h00, 1'b0, 1'b0, 0, 0, 16'h0);
    check_run("zero_gain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
